// File: rtl/zbuffer_fwd.sv
// Pipelined depth-test stage. It keeps a per-pixel depth store in a two-port RAM
// and forwards recent writes so that same-pixel fragments resolve serially.
// It also has a hardware clear sweep, started at reset or on request.
module zbuffer_fwd #(
  parameter int unsigned X_BITS  = 6,
  parameter int unsigned Y_BITS  = 6,
  parameter int unsigned DEPTH_W = 9,
  parameter int unsigned COLOR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [X_BITS-1:0]        x_in,
  input  logic [Y_BITS-1:0]        y_in,
  input  logic [DEPTH_W-1:0]       depth_in,
  input  logic [COLOR_W-1:0]       color_in,
  input  logic                     cmp_le,
  input  logic                     clear_start,
  output logic                     ready_out,
  output logic                     clear_busy,
  output logic                     valid_out,
  output logic [X_BITS+Y_BITS-1:0] pixel_addr,
  output logic [COLOR_W-1:0]       pixel_out,
  output logic [DEPTH_W-1:0]       depth_out
);

  localparam int unsigned ADDR_W = X_BITS + Y_BITS;
  localparam int unsigned N_PIX  = 2 ** ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  // The last drain cycle. At that point the youngest in-flight fragment is in S2.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  // Control state
  logic [1:0]        state, state_nxt;
  logic [1:0]        drain_cnt, drain_cnt_nxt;
  logic [ADDR_W-1:0] sweep_cnt, sweep_cnt_nxt;
  logic              ready_c;
  logic              busy_c;
  logic              sweep_we_c;
  logic              hist_clr_c;
  logic              accept_c;

  // Pipeline stages
  logic               s0_valid, s1_valid, s2_valid;
  logic [ADDR_W-1:0]  s0_addr, s1_addr, s2_addr;
  logic [DEPTH_W-1:0] s0_depth, s1_depth, s2_depth;
  logic [COLOR_W-1:0] s0_color, s1_color, s2_color;
  logic               s0_le, s1_le, s2_le;

  // Depth store and its two-stage read path
  logic [DEPTH_W-1:0] mem [0:N_PIX-1];
  logic [DEPTH_W-1:0] ram_q1, ram_q2;
  logic               ram_we_c;
  logic [ADDR_W-1:0]  ram_waddr_c;
  logic [DEPTH_W-1:0] ram_wdata_c;

  // Write history: h0 is last cycle's write, h1 is the one before
  logic               h0_valid, h1_valid;
  logic [ADDR_W-1:0]  h0_addr, h1_addr;
  logic [DEPTH_W-1:0] h0_depth, h1_depth;

  logic [DEPTH_W-1:0] stored_c;
  logic               pass_c;

  // State register. Reset always begins a full clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SWEEP;
      drain_cnt <= '0;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  // Next-state and control decode for idle / drain / sweep
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    sweep_cnt_nxt = sweep_cnt;
    ready_c       = 1'b0;
    busy_c        = 1'b0;
    sweep_we_c    = 1'b0;
    hist_clr_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (clear_start) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        busy_c = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt     = ST_SWEEP;
          sweep_cnt_nxt = '0;
        end else begin
          drain_cnt_nxt = drain_cnt + 2'd1;
        end
      end
      ST_SWEEP: begin
        busy_c     = 1'b1;
        sweep_we_c = 1'b1;
        if (sweep_cnt == {ADDR_W{1'b1}}) begin
          state_nxt  = ST_IDLE;
          hist_clr_c = 1'b1;
        end else begin
          sweep_cnt_nxt = sweep_cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt     = ST_SWEEP;
        sweep_cnt_nxt = '0;
      end
    endcase
  end

  assign ready_out  = ready_c;
  assign clear_busy = busy_c;
  assign accept_c   = valid_in & ready_c;

  // Fragment pipeline S0 -> S1 -> S2, aligned with the RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s0_addr  <= '0;
      s1_addr  <= '0;
      s2_addr  <= '0;
      s0_depth <= '0;
      s1_depth <= '0;
      s2_depth <= '0;
      s0_color <= '0;
      s1_color <= '0;
      s2_color <= '0;
      s0_le    <= 1'b0;
      s1_le    <= 1'b0;
      s2_le    <= 1'b0;
    end else begin
      s0_valid <= accept_c;
      s0_addr  <= {y_in, x_in};
      s0_depth <= depth_in;
      s0_color <= color_in;
      s0_le    <= cmp_le;
      s1_valid <= s0_valid;
      s1_addr  <= s0_addr;
      s1_depth <= s0_depth;
      s1_color <= s0_color;
      s1_le    <= s0_le;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_depth <= s1_depth;
      s2_color <= s1_color;
      s2_le    <= s1_le;
    end
  end

  // Port A: registered read, then one extra output register
  always_ff @(posedge clk) begin
    ram_q1 <= mem[s0_addr];
    ram_q2 <= ram_q1;
  end

  // Port B: the sweep owns the port while it runs. Otherwise passing fragments write.
  always_comb begin
    ram_we_c    = sweep_we_c | pass_c;
    ram_waddr_c = s2_addr;
    ram_wdata_c = s2_depth;
    if (sweep_we_c) begin
      ram_waddr_c = sweep_cnt;
      ram_wdata_c = {DEPTH_W{1'b1}};
    end
  end

  // Depth store write
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      mem[ram_waddr_c] <= ram_wdata_c;
    end
  end

  // Stored depth. Writes the RAM read missed override it, and the newest write takes precedence.
  always_comb begin
    stored_c = ram_q2;
    if (h1_valid && (h1_addr == s2_addr)) begin
      stored_c = h1_depth;
    end
    if (h0_valid && (h0_addr == s2_addr)) begin
      stored_c = h0_depth;
    end
  end

  // Depth test (unsigned). cmp_le selects a strict or non-strict compare.
  always_comb begin
    pass_c = 1'b0;
    if (s2_valid) begin
      pass_c = s2_le ? (s2_depth <= stored_c) : (s2_depth < stored_c);
    end
  end

  // History of fragment writes from the last two cycles
  always_ff @(posedge clk) begin
    if (rst || hist_clr_c) begin
      h0_valid <= 1'b0;
      h1_valid <= 1'b0;
      h0_addr  <= '0;
      h1_addr  <= '0;
      h0_depth <= '0;
      h1_depth <= '0;
    end else begin
      h1_valid <= h0_valid;
      h1_addr  <= h0_addr;
      h1_depth <= h0_depth;
      h0_valid <= pass_c;
      h0_addr  <= s2_addr;
      h0_depth <= s2_depth;
    end
  end

  assign valid_out  = pass_c;
  assign pixel_addr = s2_addr;
  assign pixel_out  = s2_color;
  assign depth_out  = s2_depth;

endmodule

// File: tb/tb_zbuffer_fwd.sv
// Scoreboard bench for zbuffer_fwd. Stimulus pushes the expected passing fragments.
// A negedge monitor pops and compares them whenever valid_out is high.
module tb_zbuffer_fwd;

  localparam int unsigned X_BITS  = 6;
  localparam int unsigned Y_BITS  = 6;
  localparam int unsigned DEPTH_W = 9;
  localparam int unsigned COLOR_W = 10;
  localparam int unsigned ADDR_W  = X_BITS + Y_BITS;
  localparam int          N_PIX   = 4096;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
    logic [DEPTH_W-1:0] depth;
    int                 cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_in;
  logic [X_BITS-1:0]  x_in;
  logic [Y_BITS-1:0]  y_in;
  logic [DEPTH_W-1:0] depth_in;
  logic [COLOR_W-1:0] color_in;
  logic               cmp_le;
  logic               clear_start;
  logic               ready_out;
  logic               clear_busy;
  logic               valid_out;
  logic [ADDR_W-1:0]  pixel_addr;
  logic [COLOR_W-1:0] pixel_out;
  logic [DEPTH_W-1:0] depth_out;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n;

  zbuffer_fwd #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .DEPTH_W(DEPTH_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .x_in(x_in), .y_in(y_in),
    .depth_in(depth_in), .color_in(color_in), .cmp_le(cmp_le),
    .clear_start(clear_start), .ready_out(ready_out), .clear_busy(clear_busy),
    .valid_out(valid_out), .pixel_addr(pixel_addr), .pixel_out(pixel_out),
    .depth_out(depth_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every valid_out must match the oldest expected fragment, including its cycle
  always @(negedge clk) begin
    if (valid_out) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_output addr=%0d color=%0h depth=%0d cyc=%0d",
                 pixel_addr, pixel_out, depth_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (pixel_addr !== mon_e.addr || pixel_out !== mon_e.color ||
            depth_out !== mon_e.depth || cyc != mon_e.cyc) begin
          failures = failures + 1;
          $display("FAIL output got addr=%0d color=%0h depth=%0d cyc=%0d expected addr=%0d color=%0h depth=%0d cyc=%0d",
                   pixel_addr, pixel_out, depth_out, cyc,
                   mon_e.addr, mon_e.color, mon_e.depth, mon_e.cyc);
        end
      end
    end
  end

  // Watchdog so a hung run still ends
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int expv);
    checks = checks + 1;
    if (got != expv) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one fragment for one cycle. Push it to the scoreboard if it should pass.
  task automatic send(input int x, input int y, input int d, input int c,
                      input bit le, input bit pass);
    exp_t e;
    valid_in = 1'b1;
    x_in     = 6'(x);
    y_in     = 6'(y);
    depth_in = 9'(d);
    color_in = 10'(c);
    cmp_le   = le;
    if (pass) begin
      e.addr  = 12'(y * 64 + x);
      e.color = 10'(c);
      e.depth = 9'(d);
      e.cyc   = cyc + 3;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  // Count cycles until ready_out rises, with a bounded wait
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready_out && cnt < 6000) begin
      @(posedge clk);
      #1;
      cnt = cnt + 1;
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; x_in = '0; y_in = '0; depth_in = '0;
    color_in = '0; cmp_le = 1'b0; clear_start = 1'b0;
    idle(3);

    // Reset state
    chk("rst_clear_busy", int'(clear_busy), 1);
    chk("rst_ready", int'(ready_out), 0);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_pixel_addr", int'(pixel_addr), 0);
    chk("rst_depth_out", int'(depth_out), 0);

    rst = 1'b0;
    wait_ready(n);
    chk("reset_sweep_cycles", n, N_PIX);
    chk("idle_clear_busy", int'(clear_busy), 0);

    // First fragment: addr 2*64+5 = 133
    send(5, 2, 100, 'h3AA, 1'b0, 1'b1);
    idle(4);

    // Depth ordering on pixel (1,1)
    send(1, 1, 50, 'h011, 1'b0, 1'b1); idle(4);
    send(1, 1, 60, 'h012, 1'b0, 1'b0); idle(4);
    send(1, 1, 40, 'h013, 1'b0, 1'b1); idle(4);

    // Back-to-back on (3,3): 80 pass, 70 pass, 75 rejected against the forwarded 70
    send(3, 3, 80, 'h031, 1'b0, 1'b1);
    send(3, 3, 70, 'h032, 1'b0, 1'b1);
    send(3, 3, 75, 'h033, 1'b0, 1'b0);
    idle(4);
    // Stored depth must now be 70
    send(3, 3, 71, 'h034, 1'b0, 1'b0); idle(4);
    send(3, 3, 70, 'h035, 1'b1, 1'b1); idle(4);

    // Gap-1 on (4,4): 80 pass, 90 rejected via the older history entry
    send(4, 4, 80, 'h041, 1'b0, 1'b1);
    idle(1);
    send(4, 4, 90, 'h042, 1'b0, 1'b0);
    idle(4);

    // Compare mode on (6,6)
    send(6, 6, 30, 'h061, 1'b0, 1'b1); idle(4);
    send(6, 6, 30, 'h062, 1'b0, 1'b0); idle(4);
    send(6, 6, 30, 'h063, 1'b1, 1'b1); idle(4);

    // All-ones depth on a cleared pixel
    send(7, 7, 511, 'h071, 1'b0, 1'b0); idle(4);
    send(7, 7, 511, 'h072, 1'b1, 1'b1); idle(4);

    // Clear mid-stream: the fragments on both sides of the clear edge still emit
    send(8, 8, 200, 'h081, 1'b0, 1'b1);
    clear_start = 1'b1;
    send(9, 9, 100, 'h091, 1'b0, 1'b1);
    clear_start = 1'b0;
    chk("clear_ready_low", int'(ready_out), 0);
    chk("clear_busy_high", int'(clear_busy), 1);
    // These must be dropped
    repeat (5) send(1, 1, 1, 'h3FF, 1'b1, 1'b0);
    wait_ready(n);
    chk("clear_ready_cycles", n + 5, 3 + N_PIX);
    chk("clear_done_busy", int'(clear_busy), 0);

    // After the clear, previously rejected depths pass
    send(1, 1, 60, 'h014, 1'b0, 1'b1); idle(1);
    send(9, 9, 150, 'h092, 1'b0, 1'b1); idle(1);
    send(3, 3, 300, 'h036, 1'b0, 1'b1); idle(4);
    send(7, 7, 511, 'h073, 1'b0, 1'b0); idle(4);
    send(7, 7, 511, 'h074, 1'b1, 1'b1); idle(4);

    // Reset mid-sweep restarts the full sweep
    clear_start = 1'b1;
    idle(1);
    clear_start = 1'b0;
    idle(100);
    chk("mid_sweep_busy", int'(clear_busy), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    wait_ready(n);
    chk("restart_sweep_cycles", n, N_PIX);

    // Reset mid-pipeline discards the in-flight fragment
    send(10, 10, 5, 'h0AA, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    wait_ready(n);
    chk("pipe_reset_sweep_cycles", n, N_PIX);
    send(10, 10, 5, 'h0AB, 1'b0, 1'b1);
    idle(6);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
